// File: rtl/tsal_indicator.sv
// TSAL indicator: debounced HV-present detection with hysteresis, sample-timeout fault and blinking red lamp.
// Optional lamp test after reset is enabled by defining TSAL_LAMPTEST_EN.
module tsal_indicator #(
    parameter int DEBOUNCE_N  = 3,
    parameter int HYST        = 4,
    parameter int BLINK_DIV   = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int LAMP_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    input  logic [7:0] comparison_value,
    output logic       green_led,
    output logic       red_led,
    output logic       hv_active,
    output logic       stale_fault
);

    localparam int DW = $clog2(DEBOUNCE_N + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [1:0] ST_SAFE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [DW-1:0] DEB_ZERO = DW'(0);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_N - 1);
    localparam logic [TW-1:0] TO_ZERO  = TW'(0);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BL_ZERO  = BW'(0);
    localparam logic [BW-1:0] BL_ONE   = BW'(1);
    localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [7:0]    HYST_V   = 8'(HYST);

`ifdef TSAL_LAMPTEST_EN
    localparam int LW = $clog2(LAMP_CYC + 1);
    localparam logic [1:0]    ST_LAMP   = 2'd3;
    localparam logic [1:0]    RST_STATE = ST_LAMP;
    localparam logic          RST_RED   = 1'b1;
    localparam logic [LW-1:0] LP_ZERO   = LW'(0);
    localparam logic [LW-1:0] LP_ONE    = LW'(1);
    localparam logic [LW-1:0] LP_LAST   = LW'(LAMP_CYC - 1);
    logic [LW-1:0] lamp_cnt_r;
    logic [LW-1:0] lamp_cnt_nxt_s;
`else
    localparam logic [1:0]    RST_STATE = ST_SAFE;
    localparam logic          RST_RED   = 1'b0;
`endif

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [DW-1:0] deb_r;
    logic [DW-1:0] deb_nxt_s;
    logic [TW-1:0] to_r;
    logic [TW-1:0] to_nxt_s;
    logic [BW-1:0] bcnt_r;
    logic [BW-1:0] bcnt_nxt_s;
    logic          blink_r;
    logic          blink_nxt_s;
    logic [7:0]    lo_s;
    logic          high_s;
    logic          low_s;
    logic          green_nxt_s;
    logic          red_nxt_s;
    logic          hv_nxt_s;
    logic          fault_nxt_s;

    // Thresholds: release level saturates at zero, which makes the low condition unreachable
    always_comb begin
        lo_s = 8'd0;
        if (comparison_value >= HYST_V) begin
            lo_s = comparison_value - HYST_V;
        end else begin
            lo_s = 8'd0;
        end
        high_s = (sample_data >= comparison_value);
        low_s  = (sample_data < lo_s);
    end

    // Next-state, debounce, timeout and blink counter logic
    always_comb begin
        state_nxt_s = state_r;
        deb_nxt_s   = deb_r;
        to_nxt_s    = to_r;
        bcnt_nxt_s  = bcnt_r;
        blink_nxt_s = blink_r;
`ifdef TSAL_LAMPTEST_EN
        lamp_cnt_nxt_s = lamp_cnt_r;
`endif
        case (state_r)
            ST_SAFE: begin
                if (sample_valid) begin
                    to_nxt_s = TO_ZERO;
                    if (high_s && (deb_r == DEB_LAST)) begin
                        state_nxt_s = ST_ACTIVE;
                        deb_nxt_s   = DEB_ZERO;
                        bcnt_nxt_s  = BL_ZERO;
                        blink_nxt_s = 1'b1;
                    end else if (high_s) begin
                        deb_nxt_s = deb_r + DEB_ONE;
                    end else begin
                        deb_nxt_s = DEB_ZERO;
                    end
                end else if (to_r == TO_LAST) begin
                    state_nxt_s = ST_FAULT;
                    deb_nxt_s   = DEB_ZERO;
                    to_nxt_s    = TO_ZERO;
                end else begin
                    to_nxt_s = to_r + TO_ONE;
                end
            end
            ST_ACTIVE: begin
                if (bcnt_r == BL_LAST) begin
                    bcnt_nxt_s  = BL_ZERO;
                    blink_nxt_s = ~blink_r;
                end else begin
                    bcnt_nxt_s = bcnt_r + BL_ONE;
                end
                if (sample_valid) begin
                    to_nxt_s = TO_ZERO;
                    if (low_s && (deb_r == DEB_LAST)) begin
                        state_nxt_s = ST_SAFE;
                        deb_nxt_s   = DEB_ZERO;
                    end else if (low_s) begin
                        deb_nxt_s = deb_r + DEB_ONE;
                    end else begin
                        deb_nxt_s = DEB_ZERO;
                    end
                end else if (to_r == TO_LAST) begin
                    state_nxt_s = ST_FAULT;
                    deb_nxt_s   = DEB_ZERO;
                    to_nxt_s    = TO_ZERO;
                end else begin
                    to_nxt_s = to_r + TO_ONE;
                end
            end
            ST_FAULT: begin
                // Any fresh sample proves the link is alive; assume HV present until debounced otherwise
                to_nxt_s = TO_ZERO;
                if (sample_valid) begin
                    state_nxt_s = ST_ACTIVE;
                    deb_nxt_s   = DEB_ZERO;
                    bcnt_nxt_s  = BL_ZERO;
                    blink_nxt_s = 1'b1;
                end else begin
                    deb_nxt_s = DEB_ZERO;
                end
            end
`ifdef TSAL_LAMPTEST_EN
            ST_LAMP: begin
                to_nxt_s  = TO_ZERO;
                deb_nxt_s = DEB_ZERO;
                if (lamp_cnt_r == LP_LAST) begin
                    state_nxt_s    = ST_SAFE;
                    lamp_cnt_nxt_s = LP_ZERO;
                end else begin
                    lamp_cnt_nxt_s = lamp_cnt_r + LP_ONE;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_FAULT;
                deb_nxt_s   = DEB_ZERO;
                to_nxt_s    = TO_ZERO;
            end
        endcase
    end

    // Moore decode of the upcoming state so the registered outputs track state_r exactly
    always_comb begin
        green_nxt_s = 1'b0;
        red_nxt_s   = 1'b1;
        hv_nxt_s    = 1'b1;
        fault_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_SAFE: begin
                green_nxt_s = 1'b1;
                red_nxt_s   = 1'b0;
                hv_nxt_s    = 1'b0;
                fault_nxt_s = 1'b0;
            end
            ST_ACTIVE: begin
                green_nxt_s = 1'b0;
                red_nxt_s   = blink_nxt_s;
                hv_nxt_s    = 1'b1;
                fault_nxt_s = 1'b0;
            end
            ST_FAULT: begin
                green_nxt_s = 1'b0;
                red_nxt_s   = 1'b1;
                hv_nxt_s    = 1'b1;
                fault_nxt_s = 1'b1;
            end
`ifdef TSAL_LAMPTEST_EN
            ST_LAMP: begin
                green_nxt_s = 1'b1;
                red_nxt_s   = 1'b1;
                hv_nxt_s    = 1'b0;
                fault_nxt_s = 1'b0;
            end
`endif
            default: begin
                green_nxt_s = 1'b0;
                red_nxt_s   = 1'b1;
                hv_nxt_s    = 1'b1;
                fault_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state_r     <= RST_STATE;
            deb_r       <= DEB_ZERO;
            to_r        <= TO_ZERO;
            bcnt_r      <= BL_ZERO;
            blink_r     <= 1'b0;
            green_led   <= 1'b1;
            red_led     <= RST_RED;
            hv_active   <= 1'b0;
            stale_fault <= 1'b0;
`ifdef TSAL_LAMPTEST_EN
            lamp_cnt_r  <= LP_ZERO;
`endif
        end else begin
            state_r     <= state_nxt_s;
            deb_r       <= deb_nxt_s;
            to_r        <= to_nxt_s;
            bcnt_r      <= bcnt_nxt_s;
            blink_r     <= blink_nxt_s;
            green_led   <= green_nxt_s;
            red_led     <= red_nxt_s;
            hv_active   <= hv_nxt_s;
            stale_fault <= fault_nxt_s;
`ifdef TSAL_LAMPTEST_EN
            lamp_cnt_r  <= lamp_cnt_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_tsal_indicator.sv
// Scoreboard bench for tsal_indicator (default build): stimulus queues expected LED/flag vectors,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_tsal_indicator;

    logic       clk;
    logic       rst_btn;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic [7:0] comparison_value;
    logic       green_led;
    logic       red_led;
    logic       hv_active;
    logic       stale_fault;

    tsal_indicator #(
        .DEBOUNCE_N  (3),
        .HYST        (4),
        .BLINK_DIV   (8),
        .TIMEOUT_CYC (64),
        .LAMP_CYC    (16)
    ) dut (
        .clk              (clk),
        .rst_btn          (rst_btn),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .comparison_value (comparison_value),
        .green_led        (green_led),
        .red_led          (red_led),
        .hv_active        (hv_active),
        .stale_fault      (stale_fault)
    );

    // Vector order {green, red, hv, fault}
    localparam logic [3:0] V_SAFE  = 4'b1000;
    localparam logic [3:0] V_ACT1  = 4'b0110;
    localparam logic [3:0] V_ACT0  = 4'b0010;
    localparam logic [3:0] V_FAULT = 4'b0111;
    localparam logic [3:0] M_ALL   = 4'b1111;
    localparam logic [3:0] M_NORED = 4'b1011;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         q_due[$];
    logic [3:0] q_exp[$];
    logic [3:0] q_mask[$];
    string      q_name[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        int         due;
        logic [3:0] exp_v;
        logic [3:0] msk;
        logic [3:0] act;
        string      nm;
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            due   = q_due.pop_front();
            exp_v = q_exp.pop_front();
            msk   = q_mask.pop_front();
            nm    = q_name.pop_front();
            act   = {green_led, red_led, hv_active, stale_fault};
            n_checks++;
            if (due != cyc) begin
                n_fail++;
                $display("FAIL %s: checked at cycle %0d, required at cycle %0d", nm, cyc, due);
            end else if ((act & msk) != (exp_v & msk)) begin
                n_fail++;
                $display("FAIL %s: got {g,r,hv,f}=%b, expected %b (mask %b)", nm, act, exp_v, msk);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
        sample_data  = 8'd0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic expect_now(input string nm, input logic [3:0] e, input logic [3:0] m);
        q_due.push_back(cyc);
        q_exp.push_back(e);
        q_mask.push_back(m);
        q_name.push_back(nm);
    endtask

    initial begin
        rst_btn          = 1'b1;
        sample_valid     = 1'b0;
        sample_data      = 8'd0;
        comparison_value = 8'd100;
        tick();
        tick();
        expect_now("reset_state", V_SAFE, M_ALL);
        rst_btn = 1'b0;

        // Activation on three threshold-level samples, then blink period
        strobe(8'd100);
        expect_now("act_after_one", V_SAFE, M_ALL);
        strobe(8'd100);
        strobe(8'd100);
        expect_now("act_entry", V_ACT1, M_ALL);
        idle(7);
        expect_now("blink_hold_7", V_ACT1, M_ALL);
        idle(1);
        expect_now("blink_toggle_8", V_ACT0, M_ALL);
        idle(8);
        expect_now("blink_toggle_16", V_ACT1, M_ALL);

        // Hysteresis band: 96 is not below lo=96
        strobe(8'd97);
        strobe(8'd97);
        strobe(8'd96);
        expect_now("band_stays_active", V_ACT0, M_NORED);
        strobe(8'd95);
        strobe(8'd95);
        expect_now("release_two_low", V_ACT0, M_NORED);
        strobe(8'd95);
        expect_now("release_to_safe", V_SAFE, M_ALL);

        // Interrupted run restarts the count
        strobe(8'd120);
        strobe(8'd90);
        strobe(8'd120);
        strobe(8'd120);
        expect_now("interrupted_run_safe", V_SAFE, M_ALL);
        strobe(8'd120);
        expect_now("interrupted_run_active", V_ACT1, M_ALL);
        strobe(8'd0);
        strobe(8'd0);
        strobe(8'd0);
        expect_now("back_to_safe_1", V_SAFE, M_ALL);

        // Debounce count holds across cycles without a strobe
        strobe(8'd100);
        idle(2);
        strobe(8'd100);
        idle(2);
        expect_now("hold_gap_safe", V_SAFE, M_ALL);
        strobe(8'd100);
        expect_now("hold_gap_active", V_ACT1, M_ALL);
        strobe(8'd50);
        strobe(8'd50);
        strobe(8'd50);
        expect_now("back_to_safe_2", V_SAFE, M_ALL);

        // Sample timeout: strobe in the expiring cycle wins, full silence faults
        strobe(8'd50);
        idle(63);
        strobe(8'd50);
        expect_now("timeout_rescued", V_SAFE, M_ALL);
        idle(63);
        expect_now("timeout_63_idle", V_SAFE, M_ALL);
        idle(1);
        expect_now("timeout_fault", V_FAULT, M_ALL);
        idle(5);
        expect_now("fault_steady", V_FAULT, M_ALL);
        strobe(8'd10);
        expect_now("fault_recover_active", V_ACT1, M_ALL);

        // Release threshold saturation at zero
        comparison_value = 8'd2;
        repeat (5) strobe(8'd0);
        expect_now("lo_saturated", V_ACT0, M_NORED);
        comparison_value = 8'd5;
        strobe(8'd0);
        strobe(8'd0);
        expect_now("lo_one_two_low", V_ACT0, M_NORED);
        strobe(8'd0);
        expect_now("lo_one_release", V_SAFE, M_ALL);

        // Threshold change keeps the debounce count
        comparison_value = 8'd100;
        strobe(8'd100);
        strobe(8'd100);
        expect_now("cmp_change_pre", V_SAFE, M_ALL);
        comparison_value = 8'd200;
        strobe(8'd200);
        expect_now("cmp_change_active", V_ACT1, M_ALL);
        strobe(8'd150);
        strobe(8'd150);
        strobe(8'd150);
        expect_now("cmp_200_release", V_SAFE, M_ALL);

        // Reset mid-ACTIVE, and reset discarding a partial count
        comparison_value = 8'd100;
        strobe(8'd100);
        strobe(8'd100);
        strobe(8'd100);
        expect_now("pre_reset_active", V_ACT1, M_ALL);
        idle(3);
        rst_btn      = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 8'd0;
        tick();
        rst_btn      = 1'b0;
        sample_valid = 1'b0;
        expect_now("reset_mid_active", V_SAFE, M_ALL);
        strobe(8'd100);
        strobe(8'd100);
        rst_btn = 1'b1;
        tick();
        rst_btn = 1'b0;
        expect_now("reset_partial", V_SAFE, M_ALL);
        strobe(8'd100);
        strobe(8'd100);
        expect_now("reset_count_restart", V_SAFE, M_ALL);
        strobe(8'd100);
        expect_now("reset_count_done", V_ACT1, M_ALL);

        for (int i = 0; i < 10 && q_due.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q_due.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_due.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
